// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified memory port arbiter:
// FSM states, one-hot grant codes and last-grant values.
package mem_port_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE   = 2'd0;
    localparam logic [1:0] ARB_BUSY_I = 2'd1;
    localparam logic [1:0] ARB_BUSY_D = 2'd2;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_I    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

    localparam logic LAST_I = 1'b0;
    localparam logic LAST_D = 1'b1;

    // State entered after a launch carrying the given grant.
    function automatic logic [1:0] busy_for(input logic [1:0] gnt);
        logic [1:0] s;
        s = ARB_IDLE;
        if (gnt == GNT_D)
            s = ARB_BUSY_D;
        else if (gnt == GNT_I)
            s = ARB_BUSY_I;
        return s;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// arb_pick: combinational one-hot grant between fetch and data.
// Ports: req_i/req_d eligible requests, last_grant, gnt (GNT_I/GNT_D/GNT_NONE).
// Config: ARB_FAIR_EN selects round-robin; default is data-over-fetch.
module arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic       req_i,
    input  logic       req_d,
    input  logic       last_grant,
    output logic [1:0] gnt
);

`ifdef ARB_FAIR_EN
    always_comb begin
        gnt = GNT_NONE;
        if (req_i && req_d)
            // On a tie, whoever did not win last time goes first.
            gnt = (last_grant == LAST_D) ? GNT_I : GNT_D;
        else if (req_d)
            gnt = GNT_D;
        else if (req_i)
            gnt = GNT_I;
    end
`else
    // Fixed priority never looks at the grant history.
    logic unused_last;
    assign unused_last = last_grant;

    always_comb begin
        gnt = GNT_NONE;
        if (req_d)
            gnt = GNT_D;
        else if (req_i)
            gnt = GNT_I;
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous-read memory between instruction fetch and
// load/store: one-cycle launch, one-cycle response, losers stall.
// Ports: clk, rst (sync, active low); fetch if_req/if_addr/if_ready/
// if_rdata; data d_req/d_we/d_addr/d_wdata/d_ready/d_rdata; memory
// mem_en/mem_we/mem_addr/mem_wdata/mem_rdata.
// Config: define ARB_FAIR_EN for round-robin arbitration.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       we_q;
    logic       last_grant;
    logic       elig_i;
    logic       elig_d;
    logic [1:0] gnt;
    logic       launch_i;
    logic       launch_d;

    // Only the word-index bits reach the memory.
    logic unused_addr;
    assign unused_addr = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                           d_addr[31:ADDR_W+2], d_addr[1:0]};

    // A port whose response is returning this cycle may not relaunch.
    assign elig_i = if_req && (state != ARB_BUSY_I);
    assign elig_d = d_req && (state != ARB_BUSY_D);

    arb_pick u_pick (
        .req_i      (elig_i),
        .req_d      (elig_d),
        .last_grant (last_grant),
        .gnt        (gnt)
    );

    // Gating with rst keeps every output at 0 while reset is held.
    assign launch_i = rst && (gnt == GNT_I);
    assign launch_d = rst && (gnt == GNT_D);

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (launch_d) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr[ADDR_W+1:2];
            mem_wdata = d_wdata;
        end else if (launch_i) begin
            mem_en   = 1'b1;
            mem_addr = if_addr[ADDR_W+1:2];
        end
    end

    assign state_nxt = launch_d ? busy_for(GNT_D) :
                       launch_i ? busy_for(GNT_I) : ARB_IDLE;

    always_comb begin
        if_ready = 1'b0;
        if_rdata = '0;
        d_ready  = 1'b0;
        d_rdata  = '0;
        if (rst) begin
            case (state)
                ARB_BUSY_I: begin
                    if_ready = 1'b1;
                    if_rdata = mem_rdata;
                end
                ARB_BUSY_D: begin
                    d_ready = 1'b1;
                    // Stores return zero rather than stale read data.
                    if (!we_q)
                        d_rdata = mem_rdata;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ARB_IDLE;
            we_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            we_q  <= launch_d && d_we;
        end
    end

`ifdef ARB_FAIR_EN
    always_ff @(posedge clk) begin
        if (!rst)
            last_grant <= LAST_D;
        else if (launch_d)
            last_grant <= LAST_D;
        else if (launch_i)
            last_grant <= LAST_I;
    end
`else
    assign last_grant = LAST_D;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural
// synchronous-read memory and one-shot requester drivers.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              if_req = 1'b0;
    logic [31:0]       if_addr = '0;
    logic              if_ready;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [31:0]       d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic              d_ready;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [DATA_W-1:0] mem [64];

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   i_left = 0;
    int   d_left = 0;
    bit   i_done = 0;
    bit   d_done = 0;
    bit   first_d;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ready  (if_ready),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ready   (d_ready),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Memory model: write lands at the launch edge, read is registered.
    always @(posedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 64; k++)
                mem[k] <= '0;
            mem[1] <= 32'hA5A5_0001;
            mem[4] <= 32'hDEAD_BEEF;
            mem[8] <= 32'hCAFE_F00D;
            mem_rdata <= '0;
        end else if (mem_en) begin
            if (mem_we)
                mem[mem_addr] <= mem_wdata;
            else
                mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    // Monitor: pops the scoreboard on every ready pulse.
    always @(negedge clk) begin
        exp_t e;
        chk("mem_we_without_en", {31'd0, mem_we & ~mem_en}, 0);
        chk("both_ready", {31'd0, if_ready & d_ready}, 0);
        if (!if_ready)
            chk("if_rdata_idle", if_rdata, 0);
        if (!d_ready)
            chk("d_rdata_idle", d_rdata, 0);
        if (if_ready || d_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_ready", {31'd0, d_ready}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("resp_port", {31'd0, d_ready}, {31'd0, e.port});
                chk("resp_data", d_ready ? d_rdata : if_rdata, e.data);
            end
        end
    end

    // Requester drivers: keep req high until the programmed count of
    // ready pulses has been seen, then drop it at the next cycle start.
    initial begin
        forever begin
            @(negedge clk);
            if (if_ready && i_left > 0) begin
                i_left--;
                if (i_left == 0)
                    i_done = 1;
            end
            if (d_ready && d_left > 0) begin
                d_left--;
                if (d_left == 0)
                    d_done = 1;
            end
            @(posedge clk);
            #1;
            if (i_done) begin
                if_req = 0;
                i_done = 0;
            end
            if (d_done) begin
                d_req = 0;
                d_done = 0;
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((if_req || d_req || exp_q.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", {31'd0, if_req | d_req}, 0);
        next_cycle();
    endtask

    task automatic push(input logic port, input logic [31:0] data);
        exp_t e;
        e.port = port;
        e.data = data;
        exp_q.push_back(e);
    endtask

    initial begin
`ifdef ARB_FAIR_EN
        first_d = 0;
`else
        first_d = 1;
`endif
        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_en", {31'd0, mem_en}, 0);
        chk("rst_if_ready", {31'd0, if_ready}, 0);
        chk("rst_d_ready", {31'd0, d_ready}, 0);
        chk("rst_mem_addr", {26'd0, mem_addr}, 0);
        next_cycle();
        rst = 1;

        // Both requesters from IDLE.
        if (first_d) begin
            push(1, 32'hCAFE_F00D);
            push(0, 32'hDEAD_BEEF);
        end else begin
            push(0, 32'hDEAD_BEEF);
            push(1, 32'hCAFE_F00D);
        end
        if_addr = 32'h10;
        d_we = 0;
        d_addr = 32'h20;
        i_left = 1;
        d_left = 1;
        if_req = 1;
        d_req = 1;
        @(negedge clk);
        chk("tie_first_addr", {26'd0, mem_addr}, first_d ? 8 : 4);
        wait_done();

        // Fetch only, three back-to-back fetches.
        for (int k = 0; k < 3; k++)
            push(0, 32'hDEAD_BEEF);
        i_left = 3;
        if_req = 1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("fetch_en_c%0d", c), {31'd0, mem_en},
                (c % 2 == 0) ? 1 : 0);
            if (c % 2 == 0)
                chk("fetch_addr", {26'd0, mem_addr}, 4);
            next_cycle();
        end
        wait_done();

        // Store then load of the same word.
        push(1, 32'h0);
        d_we = 1;
        d_addr = 32'h08;
        d_wdata = 32'h1234_5678;
        d_left = 1;
        d_req = 1;
        @(negedge clk);
        chk("store_we", {31'd0, mem_we}, 1);
        chk("store_wdata", mem_wdata, 32'h1234_5678);
        wait_done();
        push(1, 32'h1234_5678);
        d_we = 0;
        d_left = 1;
        d_req = 1;
        wait_done();

        // Saturation: alternating grants, memory busy every cycle.
        for (int k = 0; k < 10; k++) begin
            if (((k % 2) == 0) == first_d)
                push(1, 32'hCAFE_F00D);
            else
                push(0, 32'hDEAD_BEEF);
        end
        if_addr = 32'h10;
        d_addr = 32'h20;
        i_left = 5;
        d_left = 5;
        if_req = 1;
        d_req = 1;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk);
            chk($sformatf("sat_en_c%0d", c), {31'd0, mem_en},
                (c < 10) ? 1 : 0);
            if (c < 10)
                chk($sformatf("sat_addr_c%0d", c), {26'd0, mem_addr},
                    ((((c % 2) == 0) == first_d) ? 8 : 4));
            next_cycle();
        end
        wait_done();

        // Address wrap and ignored low bits.
        push(0, 32'hA5A5_0001);
        if_addr = 32'h104;
        i_left = 1;
        if_req = 1;
        @(negedge clk);
        chk("wrap_if_addr", {26'd0, mem_addr}, 1);
        wait_done();
        push(1, 32'hCAFE_F00D);
        d_we = 0;
        d_addr = 32'hFFFF_FF23;
        d_left = 1;
        d_req = 1;
        @(negedge clk);
        chk("wrap_d_addr", {26'd0, mem_addr}, 8);
        wait_done();

        // Reset right after a data launch discards the response.
        d_addr = 32'h20;
        d_left = 1;
        d_req = 1;
        @(negedge clk);
        chk("pre_rst_launch", {31'd0, mem_en}, 1);
        next_cycle();
        rst = 0;
        d_req = 0;
        d_left = 0;
        @(negedge clk);
        chk("rst_mid_d_ready", {31'd0, d_ready}, 0);
        chk("rst_mid_d_rdata", d_rdata, 0);
        chk("rst_mid_mem_en", {31'd0, mem_en}, 0);
        chk("rst_mid_mem_addr", {26'd0, mem_addr}, 0);
        next_cycle();
        rst = 1;
        @(negedge clk);
        chk("post_rst_d_ready", {31'd0, d_ready}, 0);
        next_cycle();
        push(1, 32'hCAFE_F00D);
        d_left = 1;
        d_req = 1;
        wait_done();

        repeat (2) next_cycle();
        chk("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
